cmpacc_sched: RTL and testbench
===============================

// Module: cmpacc_sched
// PURPOSE
//  Round-robin scheduler sharing one cmpacc glyph-bounds accelerator between NREQ requesters.
//  Captures the granted requester's 64x24 bitmap and drives the accelerator (acc_bitmap, 1-cycle acc_wren).
//  Waits for acc_done, then returns acc_result tagged with the requester id over a valid/ready response port.
//  A watchdog aborts jobs that never finish. Sits between the CPU/DMA request ports and the cmpacc instance.
// PARAMETERS
//  NREQ     4     number of requesters (>=2)
//  BMW      1536  bitmap width (64 rows x 24 bits)
//  TIMEOUT  1000  max cycles in WAIT before abort
//  IDW      $clog2(NREQ)  width of rsp_id (derived, localparam)
// PORTS
//  clk          in   1         system clock, all logic on posedge
//  rst          in   1         synchronous, active-high reset
//  req          in   NREQ      per-requester request level; held until matching gnt bit
//  req_bitmap   in   NREQ*BMW  requester i bitmap at [i*BMW +: BMW]; valid while req[i]
//  gnt          out  NREQ      one-hot 1-cycle pulse: bitmap captured, requester may drop req
//  rsp_valid    out  1         response available
//  rsp_ready    in   1         consumer accepts response
//  rsp_id       out  IDW       index of requester owning the response
//  rsp_result   out  16        acc_result snapshot; 16'hFFFF on timeout
//  rsp_timeout  out  1         job aborted by watchdog
//  busy         out  1         high in any state except IDLE
//  acc_wren     out  1         1-cycle start strobe to cmpacc
//  acc_bitmap   out  BMW       registered bitmap to cmpacc; stable from LOAD until next capture
//  acc_result   in   16        cmpacc result
//  acc_done     in   1         cmpacc completion level
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0, gnt=0, acc_wren=0, acc_bitmap=0, rsp_valid=0, rsp_id=0,
//   rsp_result=0, rsp_timeout=0, busy=0, wdog=0. Reset mid-job abandons it; no response is issued.
//  FSM: IDLE -> LOAD -> FIRE -> DRAIN -> WAIT -> RESP -> IDLE.
//  IDLE: if |req, pick first set bit searching from rr_ptr upward (wrapping NREQ-1 -> 0).
//   Capture its bitmap into acc_bitmap and its index into rsp_id. Pulse gnt for that cycle.
//   Set rr_ptr = index+1 mod NREQ. Go to LOAD.
//  LOAD: 1 cycle of bitmap setup before the strobe; acc_wren=0.
//  FIRE: acc_wren=1 for exactly this cycle.
//  DRAIN: 1 cycle; acc_done ignored because it may still show the previous job. Clear wdog.
//  WAIT: wdog increments each cycle.
//   acc_done=1 -> latch acc_result into rsp_result, rsp_timeout=0, go to RESP.
//   If wdog reaches TIMEOUT-1 without done -> rsp_result=16'hFFFF, rsp_timeout=1, go to RESP.
//   acc_done wins if both happen in the same cycle.
//  RESP: rsp_valid=1, and rsp_id/rsp_result/rsp_timeout are held stable until rsp_ready.
//   On rsp_valid&rsp_ready, rsp_valid drops next cycle and the FSM returns to IDLE.
//   New requests are not granted before then.
//  Fairness: a requester holding req is granted within NREQ jobs. A req dropped before gnt is simply skipped.
//  Minimum job: done visible in WAIT's first cycle -> rsp_valid 5 cycles after gnt.
//  gnt is never asserted outside IDLE. At most one gnt bit is set at a time.
//  wdog is $clog2(TIMEOUT+1) bits and saturates; it never wraps.
// STRUCTURE
//  Package cmpacc_pkg: BMW, RES_W=16, RES_TIMEOUT=16'hFFFF, state enum
//   {IDLE,LOAD,FIRE,DRAIN,WAIT,RESP}.
//  Sub-module rr_arbiter (NREQ): combinational one-hot pick from req and rr_ptr. rr_ptr stays in the parent.
//  Parent holds the FSM, the bitmap/result registers and the watchdog.
// TESTING
//  Single req[0] with the two-empty-left/bottom bitmap, live cmpacc -> gnt[0] once, acc_wren one
//   cycle, rsp_id=0, rsp_result[4:0]=2, rsp_result[10:5]=2, rsp_timeout=0.
//  req=4'b1111 held, rsp_ready=1 -> grant order 0,1,2,3,0; exactly one response per grant.
//  Stub acc_done=0 forever -> response after DRAIN+TIMEOUT cycles with rsp_result=16'hFFFF, rsp_timeout=1.
//  rsp_ready=0 for 20 cycles with req[1] pending -> rsp fields stable, gnt[1] only after the handshake.
//  Stale acc_done=1 held from the previous job -> not accepted before WAIT; the result comes from WAIT.
//  rst pulsed during WAIT -> all outputs reach reset values next cycle; no rsp_valid; next grant from rr_ptr=0.

Source files
------------

// File: rtl/cmpacc_pkg.sv
// Shared constants and FSM encoding for the cmpacc job scheduler.
package cmpacc_pkg;
    localparam int BMW = 1536;
    localparam int RES_W = 16;
    localparam logic [RES_W-1:0] RES_TIMEOUT = 16'hFFFF;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FIRE,
        DRAIN,
        WAIT,
        RESP
    } state_t;
endpackage

// File: rtl/cmpacc_sched_rr_arbiter.sv
// Combinational round-robin pick: first set req bit at or above rr_ptr, wrapping.
module rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  rr_ptr,
    output logic [NREQ-1:0] pick,
    output logic [IDW-1:0]  pick_idx,
    output logic            any
);
    logic [IDW-1:0] idx;

    always_comb begin
        pick     = '0;
        pick_idx = '0;
        any      = 1'b0;
        idx      = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IDW'((int'(rr_ptr) + k) % NREQ);
            if (!any && req[idx]) begin
                any       = 1'b1;
                pick[idx] = 1'b1;
                pick_idx  = idx;
            end
        end
    end
endmodule

// File: rtl/cmpacc_sched.sv
// Round-robin scheduler sharing one cmpacc accelerator among NREQ requesters,
// with a watchdog that aborts jobs whose done never arrives.
module cmpacc_sched
    import cmpacc_pkg::*;
#(
    parameter  int NREQ    = 4,
    parameter  int BMW     = cmpacc_pkg::BMW,
    parameter  int TIMEOUT = 1000,
    localparam int IDW     = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*BMW-1:0]  req_bitmap,
    output logic [NREQ-1:0]      gnt,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [RES_W-1:0]     rsp_result,
    output logic                 rsp_timeout,
    output logic                 busy,
    output logic                 acc_wren,
    output logic [BMW-1:0]       acc_bitmap,
    input  logic [RES_W-1:0]     acc_result,
    input  logic                 acc_done
);
    localparam int WDW = $clog2(TIMEOUT + 1);

    state_t         state, state_nx;
    logic [IDW-1:0] rr_ptr;
    logic [WDW-1:0] wdog;
    logic           wdog_hit;
    logic [NREQ-1:0] pick;
    logic [IDW-1:0]  pick_idx;
    logic            pick_any;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req      (req),
        .rr_ptr   (rr_ptr),
        .pick     (pick),
        .pick_idx (pick_idx),
        .any      (pick_any)
    );

    assign wdog_hit = (wdog >= WDW'(TIMEOUT - 1));

    always_comb begin
        state_nx  = state;
        gnt       = '0;
        rsp_valid = 1'b0;
        busy      = (state != IDLE);
        acc_wren  = 1'b0;
        unique case (state)
            IDLE: begin
                // rst gate keeps gnt quiet while reset is held
                if (!rst) gnt = pick;
                if (pick_any) state_nx = LOAD;
            end
            LOAD:  state_nx = FIRE;
            FIRE: begin
                acc_wren = 1'b1;
                state_nx = DRAIN;
            end
            DRAIN: state_nx = WAIT;
            WAIT:  if (acc_done || wdog_hit) state_nx = RESP;
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            acc_bitmap  <= '0;
            rsp_id      <= '0;
            rsp_result  <= '0;
            rsp_timeout <= 1'b0;
            wdog        <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (pick_any) begin
                    acc_bitmap <= req_bitmap[int'(pick_idx)*BMW +: BMW];
                    rsp_id     <= pick_idx;
                    rr_ptr     <= (pick_idx == IDW'(NREQ - 1)) ? '0 : pick_idx + IDW'(1);
                end
                // done may still reflect the previous job here, so only arm the watchdog
                DRAIN: wdog <= '0;
                WAIT: begin
                    if (wdog != WDW'(TIMEOUT)) wdog <= wdog + WDW'(1);
                    if (acc_done) begin
                        rsp_result  <= acc_result;
                        rsp_timeout <= 1'b0;
                    end else if (wdog_hit) begin
                        rsp_result  <= RES_TIMEOUT;
                        rsp_timeout <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cmpacc_sched.sv
// Directed bench for cmpacc_sched with a behavioural accelerator stub and a response scoreboard.
module tb_cmpacc_sched;
    localparam int NREQ    = 4;
    localparam int BMW     = 1536;
    localparam int TIMEOUT = 20;
    localparam int IDW     = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req;
    logic [NREQ*BMW-1:0] req_bitmap;
    logic [NREQ-1:0]     gnt;
    logic                rsp_valid, rsp_ready;
    logic [IDW-1:0]      rsp_id;
    logic [15:0]         rsp_result;
    logic                rsp_timeout, busy, acc_wren;
    logic [BMW-1:0]      acc_bitmap;
    logic [15:0]         acc_result;
    logic                acc_done;

    always #5 clk = ~clk;

    cmpacc_sched #(.NREQ(NREQ), .BMW(BMW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req(req), .req_bitmap(req_bitmap), .gnt(gnt),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_timeout(rsp_timeout), .busy(busy),
        .acc_wren(acc_wren), .acc_bitmap(acc_bitmap), .acc_result(acc_result),
        .acc_done(acc_done)
    );

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [15:0]    res;
        logic           tmo;
    } rsp_t;

    rsp_t sb[$];
    int   grant_q[$];
    int   n_tests = 0, n_fail = 0;
    int   cyc = 0, gnt_cnt = 0, wren_cnt = 0, rsp_cnt = 0;
    int   gnt_cyc = 0, rise_cyc = 0, hs_cyc = 0;
    logic [15:0] exp_res [NREQ];

    int             stub_lat = 1;
    bit             stub_dead = 1'b0;
    int             since;
    logic [BMW-1:0] stub_bm;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Rows are 24-bit slices, row 63 is the bottom, bit 23 the left edge.
    function automatic logic [BMW-1:0] make_bm(input int left, input int bottom);
        logic [BMW-1:0] b;
        b = '0;
        for (int r = 0; r < 64 - bottom; r++)
            for (int c = 0; c < 24 - left; c++)
                b[r*24 + c] = 1'b1;
        return b;
    endfunction

    function automatic logic [15:0] acc_fn(input logic [BMW-1:0] b);
        int maxr, maxc;
        maxr = -1;
        maxc = -1;
        for (int r = 0; r < 64; r++)
            for (int c = 0; c < 24; c++)
                if (b[r*24 + c]) begin
                    if (r > maxr) maxr = r;
                    if (c > maxc) maxc = c;
                end
        return {5'd0, 6'(63 - maxr), 5'(23 - maxc)};
    endfunction

    task automatic set_bm(input int i, input int left, input int bottom);
        req_bitmap[i*BMW +: BMW] = make_bm(left, bottom);
        exp_res[i] = {5'd0, 6'(bottom), 5'(left)};
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Accelerator stub: done/result keep showing the previous job across the start strobe.
    always @(posedge clk) begin
        if (rst) begin
            acc_done   <= 1'b0;
            acc_result <= '0;
            since      <= 0;
        end else if (acc_wren) begin
            since   <= 1;
            stub_bm <= acc_bitmap;
        end else if (since != 0) begin
            if (since < 1000) since <= since + 1;
            acc_done <= !stub_dead && (since >= stub_lat);
            if (!stub_dead && since >= stub_lat) acc_result <= acc_fn(stub_bm);
        end
    end

    initial begin : monitor
        rsp_t           e;
        int             g;
        logic           pv, pr;
        logic [IDW-1:0] sid;
        logic [15:0]    sres;
        logic           stmo;
        pv = 1'b0;
        pr = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pv = 1'b0;
            end else begin
                if (acc_wren) wren_cnt++;
                if (gnt != '0) begin
                    chk("gnt_onehot", 32'($onehot(gnt)), 1);
                    chk("gnt_while_busy", 32'(busy), 0);
                    g = 0;
                    for (int i = 0; i < NREQ; i++) if (gnt[i]) g = i;
                    e.id = IDW'(g);
                    if (stub_dead || stub_lat > TIMEOUT) begin
                        e.res = 16'hFFFF;
                        e.tmo = 1'b1;
                    end else begin
                        e.res = exp_res[g];
                        e.tmo = 1'b0;
                    end
                    sb.push_back(e);
                    grant_q.push_back(g);
                    gnt_cnt++;
                    gnt_cyc = cyc;
                end
                if (rsp_valid) begin
                    if (!pv) rise_cyc = cyc;
                    else if (!pr) begin
                        chk("hold_id", 32'(rsp_id), 32'(sid));
                        chk("hold_result", 32'(rsp_result), 32'(sres));
                        chk("hold_timeout", 32'(rsp_timeout), 32'(stmo));
                    end
                    sid  = rsp_id;
                    sres = rsp_result;
                    stmo = rsp_timeout;
                    if (rsp_ready) begin
                        if (sb.size() == 0) chk("rsp_unexpected", 32'(rsp_valid), 0);
                        else begin
                            e = sb.pop_front();
                            chk("rsp_id", 32'(rsp_id), 32'(e.id));
                            chk("rsp_result", 32'(rsp_result), 32'(e.res));
                            chk("rsp_timeout", 32'(rsp_timeout), 32'(e.tmo));
                        end
                        rsp_cnt++;
                        hs_cyc = cyc;
                    end
                end
                pv = rsp_valid;
                pr = rsp_ready;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        sb.delete();
        grant_q.delete();
    endtask

    task automatic wait_grant(input string tag);
        int start, k;
        start = gnt_cnt;
        k = 0;
        while (gnt_cnt == start && k < 200) begin
            tick();
            k++;
        end
        chk(tag, 32'(gnt_cnt > start), 1);
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while ((sb.size() != 0 || busy) && k < 500) begin
            tick();
            k++;
        end
        chk(tag, 32'(sb.size() == 0 && !busy), 1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_gnt"}, 32'(gnt), 0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
        chk({tag, "_rsp_id"}, 32'(rsp_id), 0);
        chk({tag, "_rsp_result"}, 32'(rsp_result), 0);
        chk({tag, "_rsp_timeout"}, 32'(rsp_timeout), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_acc_wren"}, 32'(acc_wren), 0);
        chk({tag, "_acc_bitmap"}, 32'(|acc_bitmap), 0);
    endtask

    initial begin : global_guard
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench timeout");
    end

    initial begin : stim
        int w0, g0, r0, k;
        rst        = 1'b1;
        req        = '0;
        req_bitmap = '0;
        rsp_ready  = 1'b1;
        set_bm(0, 2, 2);
        set_bm(1, 3, 4);
        set_bm(2, 5, 6);
        set_bm(3, 7, 8);
        repeat (3) tick();
        chk_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // single requester, minimum-latency job
        w0 = wren_cnt;
        req = 4'b0001;
        wait_grant("t1_gnt");
        req = '0;
        wait_idle("t1_idle");
        chk("t1_gnt_cnt", 32'(gnt_cnt), 1);
        chk("t1_gnt_id", 32'(grant_q[0]), 0);
        chk("t1_wren_cnt", 32'(wren_cnt - w0), 1);
        chk("t1_latency", 32'(rise_cyc - gnt_cyc), 5);
        chk("t1_left", 32'(rsp_result[4:0]), 2);
        chk("t1_bottom", 32'(rsp_result[10:5]), 2);

        // all requesters held: round-robin order
        do_reset();
        r0 = rsp_cnt;
        req = 4'b1111;
        k = 0;
        while (grant_q.size() < 5 && k < 300) begin
            tick();
            k++;
        end
        req = '0;
        wait_idle("t2_idle");
        chk("t2_grants", 32'(grant_q.size()), 5);
        for (int i = 0; i < 5 && i < grant_q.size(); i++)
            chk("t2_order", 32'(grant_q[i]), 32'(i % NREQ));
        chk("t2_rsp_cnt", 32'(rsp_cnt - r0), 5);

        // watchdog: dead accelerator, done on last WAIT cycle, done one cycle late
        do_reset();
        stub_dead = 1'b1;
        req = 4'b0001;
        wait_grant("t3_gnt");
        req = '0;
        wait_idle("t3_idle");
        chk("t3_latency", 32'(rise_cyc - gnt_cyc), 32'(4 + TIMEOUT));
        chk("t3_timeout", 32'(rsp_timeout), 1);
        stub_dead = 1'b0;
        stub_lat = TIMEOUT;
        req = 4'b0010;
        wait_grant("t3b_gnt");
        req = '0;
        wait_idle("t3b_idle");
        chk("t3b_latency", 32'(rise_cyc - gnt_cyc), 32'(4 + TIMEOUT));
        chk("t3b_timeout", 32'(rsp_timeout), 0);
        stub_lat = TIMEOUT + 1;
        req = 4'b0100;
        wait_grant("t3c_gnt");
        req = '0;
        wait_idle("t3c_idle");
        chk("t3c_result", 32'(rsp_result), 32'hFFFF);
        stub_lat = 1;

        // response backpressure with a pending request
        rsp_ready = 1'b0;
        req = 4'b0001;
        wait_grant("t5_gnt0");
        req = '0;
        k = 0;
        while (!rsp_valid && k < 50) begin
            tick();
            k++;
        end
        chk("t5_valid", 32'(rsp_valid), 1);
        req = 4'b0010;
        g0 = gnt_cnt;
        repeat (20) tick();
        chk("t5_no_gnt", 32'(gnt_cnt), 32'(g0));
        chk("t5_valid_held", 32'(rsp_valid), 1);
        rsp_ready = 1'b1;
        wait_grant("t5_gnt1");
        req = '0;
        chk("t5_gnt1_id", 32'(grant_q[$]), 1);
        chk("t5_gnt_after_hs", 32'(gnt_cyc > hs_cyc), 1);
        wait_idle("t5_idle");

        // stale done from previous job must not be taken in DRAIN
        chk("t6_stale_done", 32'(acc_done), 1);
        stub_lat = 3;
        req = 4'b0100;
        wait_grant("t6_gnt");
        req = '0;
        wait_idle("t6_idle");
        chk("t6_latency", 32'(rise_cyc - gnt_cyc), 7);
        stub_lat = 1;

        // reset during WAIT abandons the job and restarts round-robin at 0
        stub_dead = 1'b1;
        req = 4'b0100;
        wait_grant("t7_gnt");
        req = '0;
        repeat (5) tick();
        chk("t7_busy", 32'(busy), 1);
        rst = 1'b1;
        tick();
        chk_reset_outputs("t7_rst");
        rst = 1'b0;
        sb.delete();
        stub_dead = 1'b0;
        req = 4'b1010;
        wait_grant("t7_gnt2");
        req = '0;
        chk("t7_rr_restart", 32'(grant_q[$]), 1);
        wait_idle("t7_idle");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
